jtkicker_prog_post: RTL and testbench



---
 rtl/jtkicker_prog_post_if.sv | 27 ++
 rtl/jtkicker_prog_post.sv | 172 +++++++++++++++++
 tb/tb_jtkicker_prog_post.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/jtkicker_prog_post_if.sv
// Download write bus into the post-processor and the write-request bus out of it.
interface jtkicker_prog_post_if #(
  parameter int AW = 22,
  parameter int DW = 8
);
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_we;
  logic          in_rdy;
  logic          dwn_on;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_we;
  logic          out_ack;

  // Download source and downstream memory side
  modport master (
    output in_addr, in_data, in_we, dwn_on, out_ack,
    input  in_rdy, out_addr, out_data, out_we
  );

  // Post-processor side
  modport slave (
    input  in_addr, in_data, in_we, dwn_on, out_ack,
    output in_rdy, out_addr, out_data, out_we
  );
endinterface

// File: rtl/jtkicker_prog_post.sv
// Download post-processor: per-region address swizzle / nibble swap, one
// outstanding write towards memory, variant-signature capture and end-of-
// download pulse once the last write has drained.
module jtkicker_prog_post #(
  parameter int            AW       = 22,
  parameter int            DW       = 8,
  parameter int            NREG     = 4,
  parameter logic [AW-1:0] SIG_ADDR = {AW{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  jtkicker_prog_post_if.slave  bus,
  input  logic [AW*NREG-1:0]   reg_start,
  input  logic [AW-1:0]        reg_end,
  input  logic [2*NREG-1:0]    reg_mode,
  output logic                 is_variant,
  output logic [AW-1:0]        wr_cnt,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic                  dwn_on_r, done_pend_r;
  logic                  in_rdy_r, out_we_r, done_r, is_variant_r;
  logic [AW-1:0]         out_addr_r, wr_cnt_r;
  logic [DW-1:0]         out_data_r;
  logic                  accept_s, fall_s, rise_s, hit_s;
  logic [1:0]            mode_s;
  logic [AW-1:0]         lo_s, hi_s;
  logic [AW*(NREG+1)-1:0] bounds_s;

  // Address swizzle for a given region mode; modes 0 and 3 keep the address
  function automatic logic [AW-1:0] swz_addr(input logic [AW-1:0] a, input logic [1:0] m);
    logic [AW-1:0] r;
    r = a;
    case (m)
      2'd1:    r = {a[AW-1:4], a[2:0], ~a[3]};
      2'd2:    r = {a[AW-1:5], a[2:0], ~a[4], ~a[3]};
      default: r = a;
    endcase
    return r;
  endfunction

  // Nibble swap in mode 3, only meaningful for byte-wide data
  function automatic logic [DW-1:0] swz_data(input logic [DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] r;
    r = d;
    if (DW == 8 && m == 2'd3) begin
      r = {d[DW-5:0], d[DW-1:DW-4]};
    end else begin
      r = d;
    end
    return r;
  endfunction

  assign bounds_s = {reg_end, reg_start};
  assign accept_s = (state_r == S_IDLE) && bus.in_we;
  assign fall_s   = dwn_on_r && !bus.dwn_on;
  assign rise_s   = !dwn_on_r && bus.dwn_on;

  // Region decode: first region whose [start, next start) holds the address
  always_comb begin
    mode_s = 2'd0;
    hit_s  = 1'b0;
    lo_s   = {AW{1'b0}};
    hi_s   = {AW{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      lo_s = bounds_s[i*AW +: AW];
      hi_s = bounds_s[(i+1)*AW +: AW];
      if (!hit_s && (bus.in_addr >= lo_s) && (bus.in_addr < hi_s)) begin
        hit_s  = 1'b1;
        mode_s = reg_mode[2*i +: 2];
      end else begin
        hit_s  = hit_s;
        mode_s = mode_s;
      end
    end
  end

  // Next-state logic: accept in IDLE, hold in PEND until ack, DONE after drain
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.in_we) begin
          state_next_s = S_PEND;
        end else if (done_pend_r || fall_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_PEND: begin
        if (bus.out_ack) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_PEND;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs, captured write, counters and download-edge tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      dwn_on_r     <= 1'b0;
      done_pend_r  <= 1'b0;
      in_rdy_r     <= 1'b1;
      out_we_r     <= 1'b0;
      done_r       <= 1'b0;
      is_variant_r <= 1'b0;
      out_addr_r   <= {AW{1'b0}};
      out_data_r   <= {DW{1'b0}};
      wr_cnt_r     <= {AW{1'b0}};
    end else begin
      dwn_on_r <= bus.dwn_on;
      in_rdy_r <= (state_next_s == S_IDLE);
      out_we_r <= (state_next_s == S_PEND);
      done_r   <= (state_next_s == S_DONE);
      // A falling edge seen while a write is outstanding waits for the drain
      if (state_next_s == S_DONE) begin
        done_pend_r <= 1'b0;
      end else begin
        done_pend_r <= done_pend_r || fall_s;
      end
      if (accept_s) begin
        out_addr_r <= swz_addr(bus.in_addr, mode_s);
        out_data_r <= swz_data(bus.in_data, mode_s);
      end else begin
        out_addr_r <= out_addr_r;
        out_data_r <= out_data_r;
      end
      if (accept_s && (bus.in_addr == SIG_ADDR)) begin
        is_variant_r <= &bus.in_data;
      end else begin
        is_variant_r <= is_variant_r;
      end
      if (rise_s) begin
        wr_cnt_r <= accept_s ? {{(AW-1){1'b0}}, 1'b1} : {AW{1'b0}};
      end else if (accept_s && (wr_cnt_r != {AW{1'b1}})) begin
        wr_cnt_r <= wr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end
    end
  end

  assign bus.in_rdy   = in_rdy_r;
  assign bus.out_we   = out_we_r;
  assign bus.out_addr = out_addr_r;
  assign bus.out_data = out_data_r;
  assign is_variant   = is_variant_r;
  assign wr_cnt       = wr_cnt_r;
  assign done         = done_r;

endmodule

// File: tb/tb_jtkicker_prog_post.sv
// Self-checking bench for jtkicker_prog_post: directed examples plus random
// writes checked against an arithmetic reference of the region/swizzle rules.
module tb_jtkicker_prog_post;
  localparam int AW = 22;
  localparam int DW = 8;
  localparam int NREG = 4;
  localparam logic [AW-1:0] SIG = 22'h20001;

  logic clk, rst;
  logic [AW*NREG-1:0] reg_start;
  logic [AW-1:0] reg_end;
  logic [2*NREG-1:0] reg_mode;
  logic is_variant, done;
  logic [AW-1:0] wr_cnt;

  jtkicker_prog_post_if #(.AW(AW), .DW(DW)) bus ();

  jtkicker_prog_post #(.AW(AW), .DW(DW), .NREG(NREG), .SIG_ADDR(SIG)) dut (
    .clk(clk), .rst(rst), .bus(bus), .reg_start(reg_start), .reg_end(reg_end),
    .reg_mode(reg_mode), .is_variant(is_variant), .wr_cnt(wr_cnt), .done(done)
  );

  int checks = 0;
  int failures = 0;
  int unsigned m_start[4] = '{32'h0, 32'h8000, 32'h10000, 32'h18000};
  int unsigned m_end = 32'h20000;
  int unsigned m_mode[4] = '{0, 1, 2, 3};
  int unsigned m_cnt = 0;
  logic m_var = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_regions;
    for (int i = 0; i < NREG; i++) begin
      reg_start[i*AW +: AW] = m_start[i][AW-1:0];
      reg_mode[2*i +: 2] = m_mode[i][1:0];
    end
    reg_end = m_end[AW-1:0];
  endtask

  function automatic int unsigned region_mode(input int unsigned a);
    for (int i = 0; i < NREG; i++) begin
      if (a >= m_start[i] && a < ((i == NREG-1) ? m_end : m_start[i+1])) return m_mode[i];
    end
    return 0;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int unsigned a);
    int unsigned m, r;
    m = region_mode(a);
    if (m == 1) r = (a & ~32'hF) | ((a & 7) * 2) | (((a / 8) & 1) ^ 1);
    else if (m == 2) r = (a & ~32'h1F) | ((a & 7) * 4) | ((((a / 16) & 1) ^ 1) * 2) | (((a / 8) & 1) ^ 1);
    else r = a;
    return r[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] exp_data(input int unsigned a, input int unsigned d);
    int unsigned r;
    r = (region_mode(a) == 3) ? (((d & 15) * 16) | (d / 16)) : d;
    return r[DW-1:0];
  endfunction

  // Full write transaction with ack delayed dly cycles after out_we rises
  task automatic do_write(input int unsigned a, input int unsigned d, input int dly);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ea = exp_addr(a);
    ed = exp_data(a, d);
    checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL wr_rdy_before got=%0h exp=1", bus.in_rdy); end
    bus.in_addr = a[AW-1:0]; bus.in_data = d[DW-1:0]; bus.in_we = 1'b1;
    tick;
    bus.in_we = 1'b0;
    if (m_cnt != 32'h3FFFFF) m_cnt++;
    if (a[AW-1:0] == SIG) m_var = (d[7:0] == 8'hFF);
    checks++; if (bus.out_we !== 1'b1) begin failures++; $display("FAIL wr_we got=%0h exp=1 addr=%0h", bus.out_we, a); end
    checks++; if (bus.out_addr !== ea) begin failures++; $display("FAIL wr_addr in=%0h got=%0h exp=%0h", a, bus.out_addr, ea); end
    checks++; if (bus.out_data !== ed) begin failures++; $display("FAIL wr_data in=%0h got=%0h exp=%0h", a, bus.out_data, ed); end
    checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL wr_rdy_pend got=%0h exp=0", bus.in_rdy); end
    checks++; if (wr_cnt !== m_cnt[AW-1:0]) begin failures++; $display("FAIL wr_cnt got=%0h exp=%0h", wr_cnt, m_cnt); end
    checks++; if (is_variant !== m_var) begin failures++; $display("FAIL wr_variant got=%0h exp=%0h", is_variant, m_var); end
    for (int k = 0; k < dly; k++) begin
      tick;
      checks++; if (bus.out_we !== 1'b1 || bus.out_addr !== ea) begin failures++; $display("FAIL wr_hold we=%0h addr=%0h exp_addr=%0h", bus.out_we, bus.out_addr, ea); end
    end
    bus.out_ack = 1'b1;
    tick;
    bus.out_ack = 1'b0;
    checks++; if (bus.out_we !== 1'b0 || bus.in_rdy !== 1'b1) begin failures++; $display("FAIL wr_release we=%0h rdy=%0h exp we=0 rdy=1", bus.out_we, bus.in_rdy); end
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick; rst = 1'b0;
    checks++; if (bus.out_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", bus.out_we); end
    checks++; if (bus.out_addr !== 22'h0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", bus.out_addr); end
    checks++; if (bus.out_data !== 8'h0) begin failures++; $display("FAIL rst_data got=%0h exp=0", bus.out_data); end
    checks++; if (wr_cnt !== 22'h0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", wr_cnt); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0h exp=0", done); end
    checks++; if (is_variant !== 1'b0) begin failures++; $display("FAIL rst_variant got=%0h exp=0", is_variant); end
    checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL rst_rdy got=%0h exp=1", bus.in_rdy); end
  endtask

  task automatic test_directed;
    bus.dwn_on = 1'b1; tick; m_cnt = 0;
    checks++; if (wr_cnt !== 22'h0) begin failures++; $display("FAIL dl_start_cnt got=%0h exp=0", wr_cnt); end
    do_write(32'h8009, 32'h5A, 0);
    checks++; if (bus.out_addr !== 22'h8002) begin failures++; $display("FAIL ex_mode1 got=%0h exp=8002", bus.out_addr); end
    do_write(32'h10008, 32'h3C, 1);
    checks++; if (bus.out_addr !== 22'h10002) begin failures++; $display("FAIL ex_mode2 got=%0h exp=10002", bus.out_addr); end
    do_write(32'h18000, 32'h3C, 2);
    checks++; if (bus.out_data !== 8'hC3) begin failures++; $display("FAIL ex_mode3 got=%0h exp=c3", bus.out_data); end
  endtask

  task automatic test_stall;
    logic [AW-1:0] ea;
    ea = exp_addr(32'h8005);
    bus.in_addr = 22'h8005; bus.in_data = 8'h11; bus.in_we = 1'b1;
    tick;
    m_cnt++;
    for (int k = 0; k < 5; k++) begin
      bus.in_we = 1'b1; bus.in_addr = 22'h10008 + k[AW-1:0]; bus.in_data = 8'hEE;
      reg_mode = 8'h00;
      tick;
      checks++; if (bus.out_we !== 1'b1 || bus.out_addr !== ea || bus.out_data !== 8'h11) begin failures++; $display("FAIL stall_hold we=%0h addr=%0h data=%0h exp addr=%0h data=11", bus.out_we, bus.out_addr, bus.out_data, ea); end
      checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL stall_rdy got=%0h exp=0", bus.in_rdy); end
    end
    bus.in_we = 1'b0;
    apply_regions;
    checks++; if (wr_cnt !== m_cnt[AW-1:0]) begin failures++; $display("FAIL stall_cnt got=%0h exp=%0h", wr_cnt, m_cnt); end
    bus.out_ack = 1'b1; tick; bus.out_ack = 1'b0;
    checks++; if (bus.out_we !== 1'b0 || wr_cnt !== m_cnt[AW-1:0]) begin failures++; $display("FAIL stall_end we=%0h cnt=%0h exp we=0 cnt=%0h", bus.out_we, wr_cnt, m_cnt); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++) m_mode[i] = $urandom_range(0, 3);
      apply_regions;
      for (int n = 0; n < 12; n++) begin
        do_write($urandom_range(0, 32'h23FFF), $urandom_range(0, 255), $urandom_range(0, 3));
      end
    end
    m_mode = '{0, 1, 2, 3};
    apply_regions;
  endtask

  task automatic test_variant;
    do_write(SIG, 32'hFF, 0);
    checks++; if (is_variant !== 1'b1) begin failures++; $display("FAIL var_set got=%0h exp=1", is_variant); end
    bus.dwn_on = 1'b0; tick;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL idle_done got=%0h exp=1", done); end
    tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL idle_done_end got=%0h exp=0", done); end
    bus.dwn_on = 1'b1; tick; m_cnt = 0;
    checks++; if (wr_cnt !== 22'h0) begin failures++; $display("FAIL var_cnt_clear got=%0h exp=0", wr_cnt); end
    do_write(SIG, 32'hFE, 1);
    checks++; if (is_variant !== 1'b0) begin failures++; $display("FAIL var_clear got=%0h exp=0", is_variant); end
  endtask

  task automatic test_done_pend;
    int pulses;
    bus.in_addr = 22'h00123; bus.in_data = 8'h42; bus.in_we = 1'b1;
    tick; bus.in_we = 1'b0; m_cnt++;
    bus.dwn_on = 1'b0;
    tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL dp_early1 got=%0h exp=0", done); end
    tick;
    checks++; if (done !== 1'b0 || bus.out_we !== 1'b1) begin failures++; $display("FAIL dp_early2 done=%0h we=%0h exp done=0 we=1", done, bus.out_we); end
    bus.out_ack = 1'b1; tick; bus.out_ack = 1'b0;
    checks++; if (done !== 1'b0 || bus.out_we !== 1'b0) begin failures++; $display("FAIL dp_ack done=%0h we=%0h exp 0 0", done, bus.out_we); end
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (done === 1'b1) pulses++;
      if (k == 0) begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL dp_pulse_time got=%0h exp=1", done); end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL dp_pulse_count got=%0d exp=1", pulses); end
    bus.dwn_on = 1'b1; tick; m_cnt = 0;
  endtask

  task automatic test_reset_pend;
    bus.in_addr = 22'h08001; bus.in_data = 8'h77; bus.in_we = 1'b1;
    tick; bus.in_we = 1'b0;
    checks++; if (bus.out_we !== 1'b1) begin failures++; $display("FAIL rp_pend got=%0h exp=1", bus.out_we); end
    rst = 1'b1; tick; rst = 1'b0;
    m_cnt = 0; m_var = 1'b0;
    checks++; if (bus.out_we !== 1'b0 || wr_cnt !== 22'h0 || bus.in_rdy !== 1'b1) begin failures++; $display("FAIL rp_after we=%0h cnt=%0h rdy=%0h exp 0 0 1", bus.out_we, wr_cnt, bus.in_rdy); end
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (bus.out_we !== 1'b0) begin failures++; $display("FAIL rp_no_we got=%0h exp=0", bus.out_we); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_addr = 22'h0; bus.in_data = 8'h0; bus.in_we = 1'b0;
    bus.dwn_on = 1'b0; bus.out_ack = 1'b0;
    apply_regions;
    test_reset;
    test_directed;
    test_stall;
    test_random;
    test_variant;
    test_done_pend;
    test_reset_pend;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
